// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle, valid/ready on both sides.
// Optional macro SEQ_MULT_EARLY_TERM_EN stops iterating once the remaining multiplier bits are all zero.
module seq_shift_add_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_p;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     w_mplier_sh;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 w_accept;
  logic                 w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mplier_sh = r_mplier >> 1;
    w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
    w_last      = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_sh == '0);
`else
    w_last      = (r_cnt == CNT_W'(WIDTH - 1));
`endif
    case (r_state)
      IDLE: begin
        w_accept = in_valid & r_in_ready;
        if (w_accept) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (r_out_valid && out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_sh;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) r_p <= w_acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign P         = r_p;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed-vector bench for seq_shift_add_mult (WIDTH=8); outputs sampled on the falling edge.
module tb_seq_shift_add_mult;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     A = '0;
  logic [W-1:0]     B = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   P;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready) n_hs++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Edges after the accepting edge until out_valid is seen.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input int stall, input bit hold_valid);
    int lat;
    int bad;
    int hs0;
    chk({tag, "_rdy_pre"}, 32'(in_ready), 1);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    out_ready = (stall == 0);
    hs0       = n_hs;
    @(negedge clk);
    if (!hold_valid) begin
      in_valid = 1'b0;
      A = 'x;
      B = 'x;
    end
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) bad++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
    chk({tag, "_p"}, 32'(P), 32'(exp_p));
    chk({tag, "_busy_rdy"}, 32'(bad), 0);
    chk({tag, "_rdy_done"}, 32'(in_ready), 0);
    if (stall > 0) begin
      bad = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!out_valid || P !== exp_p || in_ready) bad++;
      end
      chk({tag, "_stall_hold"}, 32'(bad), 0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, 32'(out_valid), 0);
    chk({tag, "_rdy_after"}, 32'(in_ready), 1);
    chk({tag, "_p_kept"}, 32'(P), 32'(exp_p));
    chk({tag, "_n_hs"}, 32'(n_hs - hs0), 1);
  endtask

  initial begin
    int bad;
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 0);
      chk("rst_p", 32'(P), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy_first", 32'(in_ready), 1);

    run_op("one", 8'd1, 8'd1, 16'd1, 0, 1'b0);
    run_op("m2x3", 8'd2, 8'd3, 16'd6, 0, 1'b0);
    run_op("m3x3", 8'd3, 8'd3, 16'd9, 0, 1'b0);
    run_op("m2x2", 8'd2, 8'd2, 16'd4, 0, 1'b0);
    run_op("m1x2", 8'd1, 8'd2, 16'd2, 0, 1'b0);
    run_op("max", 8'd255, 8'd255, 16'd65025, 0, 1'b0);
    run_op("m13x11", 8'd13, 8'd11, 16'd143, 0, 1'b0);
    run_op("bp", 8'd3, 8'd3, 16'd9, 20, 1'b0);
    run_op("zA", 8'd0, 8'd255, 16'd0, 0, 1'b1);
    run_op("zB", 8'd255, 8'd0, 16'd0, 0, 1'b1);
    run_op("e5x1", 8'd5, 8'd1, 16'd5, 0, 1'b0);
    run_op("e5x80", 8'd5, 8'h80, 16'd640, 0, 1'b0);
    run_op("e7x0", 8'd7, 8'd0, 16'd0, 0, 1'b0);

    // Abort mid-operation with a one-cycle reset pulse.
    in_valid = 1'b1;
    A = 8'd200;
    B = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 32'(in_ready), 0);
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_p", 32'(P), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rdy_back", 32'(in_ready), 1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("mid_no_ov", 32'(bad), 0);
    run_op("post_rst", 8'd2, 8'd1, 16'd2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Sequential shift-add multiplier. It is the responder to the stimulus-driving multiplier benches.
- Accepts operand pairs A/B over a valid/ready handshake.
- Computes the unsigned product over multiple cycles and presents P over a valid/ready handshake.
- Serves as the area-minimal reference point in the multiplier design-space exploration, next to the combinational array variants.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair A/B valid.
- in_ready  out  1  block can accept operands; registered.
- A  in  WIDTH  multiplicand, unsigned.
- B  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  P holds a finished product.
- out_ready  in  1  consumer accepts P.
- P  out  2*WIDTH  product, unsigned.
- busy  out  1  high while in CALC or DONE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values, while rst=1 at a clk edge:
  - state=IDLE; in_ready=0, out_valid=0, busy=0, P=0.
  - Accumulator, shifted multiplicand, shifted multiplier and counter all 0.
- First cycle after rst deasserts: in_ready=1.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid & in_ready at edge T: capture mcand={WIDTH'b0,A}, mplier=B; acc=0, cnt=0.
  - Next state CALC; in_ready=0 and busy=1 from T+1.
  - A/B are ignored when no handshake occurs.
- CALC, one iteration per cycle:
  - If mplier[0]=1, acc <= acc + mcand (2*WIDTH-bit add, carry-out discarded; it cannot overflow).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches WIDTH-1 in this cycle, the next state is DONE and P <= the final acc value, including this cycle's add.
  - in_valid is ignored.
- DONE:
  - out_valid=1; P stable.
  - On out_valid & out_ready: next state IDLE; out_valid=0 and in_ready=1 next cycle.
  - Back-to-back accept in the same cycle is not supported; minimum initiation interval is WIDTH+2 cycles.
- Latency: input handshake at edge T gives out_valid=1 from cycle T+WIDTH+1.
- Backpressure: out_ready=0 holds DONE indefinitely, with P and out_valid stable.
- P after output handshake: keeps the last product until the next DONE load; only out_valid drops.
- Boundary cases:
  - A=0 or B=0 gives P=0 with normal latency.
  - A=B=2^WIDTH-1 gives P=2^(2*WIDTH)-2^(WIDTH+1)+1, with no truncation.
- Reset mid-operation: rst in CALC or DONE aborts the operation. Outputs go to reset values and the in-flight result is lost, with no partial out_valid.
- Simultaneous rst and any handshake: rst wins.
- X on A/B without a handshake must not propagate into state.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: CALC exits to DONE as soon as the post-shift mplier is 0.
  - Number of CALC cycles = max(1, index of highest set bit of B + 1).
  - B=0 gives out_valid at T+2; B=1 at T+2; B=8'h80 at T+9.
  - P values are identical to the feature-off build.
- Undefined: CALC always runs exactly WIDTH cycles; no zero-detect logic is synthesized.

Test Plan:
- Reset then single op, WIDTH=8: hold rst 3 cycles, then A=1, B=1 handshake at T -> out_valid rises at T+9, P=1; in_ready=0 during T+1..T+9.
- Products sequence: (2,3), (3,3), (2,2), (1,2), (255,255) with out_ready=1 -> P=6, 9, 4, 2, 65025 in order; each transaction takes WIDTH+2 cycles.
- Backpressure: A=3, B=3, out_ready=0 for 20 cycles then 1 -> out_valid high with P=9 the whole time; exactly one output handshake; in_ready=1 the cycle after.
- Mid-op reset: A=200, B=200 accepted, rst pulsed at T+4 -> out_valid stays 0; in_ready=0 during rst, then 1; next op A=2, B=1 yields P=2.
- Zero operands: A=0, B=255 -> P=0; A=255, B=0 -> P=0; in_valid held high while busy is not re-accepted (one result per handshake).
- With SEQ_MULT_EARLY_TERM_EN: A=5, B=1 -> P=5 at T+2; A=5, B=8'h80 -> P=640 at T+9; A=7, B=0 -> P=0 at T+2.
